// File: rtl/tmr_fault_logger.sv
`default_nettype none
// ============================================================================
// Module   : tmr_fault_logger
// Brief    : Timestamped TMR fault/trojan event logger with FIFO and a sticky
//            trojan-alarm state machine.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_fault_logger #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 16,
    parameter int THRESH = 3,
    parameter int QUIET  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       fault_flag,
    input  logic                       sus_trojan,
    input  logic                       log_ready,
    input  logic                       clr_alarm,
    output logic                       log_valid,
    output logic [2+TS_W+WIDTH-1:0]    log_data,
    output logic                       alarm,
    output logic [1:0]                 state_o,
    output logic [7:0]                 drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = 2 + TS_W + WIDTH;
    localparam int c_SW = $clog2(THRESH + 1);
    localparam int c_QW = $clog2(QUIET + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WATCH = 2'd1;
    localparam logic [1:0] c_ALARM = 2'd2;

    logic [TS_W-1:0] r_ts;
    logic [1:0]      r_prev_type;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [7:0]      r_drop;
    logic [c_EW-1:0] r_mem [DEPTH];

    logic [1:0]      r_state;
    logic [c_SW-1:0] r_streak;
    logic [c_QW-1:0] r_quiet;
    logic            r_alarm;

    logic [1:0]      w_type;
    logic            w_event;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_SW-1:0] w_streak_inc;
    logic [c_QW-1:0] w_quiet_inc;

    // An event fires only on a change to a non-zero type, so a held type logs once.
    assign w_type    = {sus_trojan, fault_flag};
    assign w_event   = (w_type != 2'b00) && (w_type != r_prev_type);
    assign w_full    = (r_count == c_CW'(DEPTH));
    assign log_valid = (r_count != '0);
    assign w_pop     = log_valid && log_ready;
    assign w_push    = w_event && (!w_full || w_pop);
    assign w_drop    = w_event && w_full && !w_pop;

    assign log_data   = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign drop_cnt   = r_drop;
    assign alarm      = r_alarm;
    assign state_o    = r_state;

    assign w_streak_inc = r_streak + c_SW'(1);
    assign w_quiet_inc  = r_quiet + c_QW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts        <= '0;
            r_prev_type <= 2'b00;
        end else begin
            r_ts        <= r_ts + TS_W'(1);
            r_prev_type <= w_type;
        end
    end

    // When full, a simultaneous pop frees the head slot, which is the one
    // the write pointer already addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr] <= {w_type, r_ts, data_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_streak <= '0;
            r_quiet  <= '0;
            r_alarm  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (sus_trojan) begin
                        r_state  <= c_WATCH;
                        r_streak <= c_SW'(1);
                        r_quiet  <= '0;
                    end
                end
                c_WATCH: begin
                    if (sus_trojan) begin
                        r_quiet  <= '0;
                        r_streak <= w_streak_inc;
                        if (w_streak_inc == c_SW'(THRESH)) begin
                            r_state <= c_ALARM;
                            r_alarm <= 1'b1;
                        end
                    end else begin
                        r_streak <= '0;
                        if (w_quiet_inc == c_QW'(QUIET)) begin
                            r_state <= c_IDLE;
                            r_quiet <= '0;
                        end else begin
                            r_quiet <= w_quiet_inc;
                        end
                    end
                end
                c_ALARM: begin
                    // Sticky: only an operator clear during a quiet cycle releases it.
                    if (clr_alarm && !sus_trojan) begin
                        r_state  <= c_IDLE;
                        r_alarm  <= 1'b0;
                        r_streak <= '0;
                        r_quiet  <= '0;
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_alarm  <= 1'b0;
                    r_streak <= '0;
                    r_quiet  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_fault_logger
// Brief    : Scoreboard bench for tmr_fault_logger with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_fault_logger;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        fault_flag;
    logic        sus_trojan;
    logic        log_ready;
    logic        clr_alarm;
    logic        log_valid;
    logic [25:0] log_data;
    logic        alarm;
    logic [1:0]  state_o;
    logic [7:0]  drop_cnt;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_err    = 0;

    logic [25:0] exp_q[$];
    logic [25:0] r_exp;

    tmr_fault_logger #(
        .WIDTH (8),
        .DEPTH (4),
        .TS_W  (16),
        .THRESH(3),
        .QUIET (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .fault_flag(fault_flag),
        .sus_trojan(sus_trojan),
        .log_ready (log_ready),
        .clr_alarm (clr_alarm),
        .log_valid (log_valid),
        .log_data  (log_data),
        .alarm     (alarm),
        .state_o   (state_o),
        .drop_cnt  (drop_cnt),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and hold for the cycle.
    task automatic step(input logic ff, input logic st, input logic [7:0] d,
                        input logic lr, input logic clr);
        fault_flag = ff;
        sus_trojan = st;
        data_in    = d;
        log_ready  = lr;
        clr_alarm  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Monitor: every accepted entry is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && log_valid && log_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pop: got %0h expected none", log_data);
            end else begin
                r_exp = exp_q.pop_front();
                if (log_data !== r_exp) begin
                    n_err++;
                    $display("FAIL log_entry: got %0h expected %0h", log_data, r_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();

        // Reset state
        chk("rst_state", state_o, 2'd0);
        chk("rst_alarm", alarm, 1'b0);
        chk("rst_valid", log_valid, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_drop", drop_cnt, 8'd0);

        // Held fault_flag over cycles 5..9 logs a single entry at ts=5
        exp_q.push_back({2'b01, 16'd5, 8'hA5});
        for (int c = 0; c <= 12; c++) begin
            chk($sformatf("valid_c%0d", c), log_valid, (c == 6) ? 1 : 0);
            step((c >= 5 && c <= 9), 1'b0, 8'hA5, 1'b1, 1'b0);
        end
        chk("single_count", fifo_count, 3'd0);
        chk("single_q_empty", exp_q.size(), 0);

        // Six alternating events with no consumer: four stored, two dropped
        do_reset();
        exp_q.push_back({2'b01, 16'd1, 8'h11});
        exp_q.push_back({2'b11, 16'd2, 8'h12});
        exp_q.push_back({2'b01, 16'd3, 8'h13});
        exp_q.push_back({2'b11, 16'd4, 8'h14});
        for (int c = 0; c <= 6; c++) begin
            if (c == 0) step(1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
            else        step(1'b1, (c % 2) == 0, 8'(8'h10 + c), 1'b0, 1'b0);
        end
        chk("full_count", fifo_count, 3'd4);
        chk("full_drop", drop_cnt, 8'd2);
        chk("full_valid", log_valid, 1'b1);

        // Push and pop together while full
        exp_q.push_back({2'b10, 16'd7, 8'h77});
        step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("pp_count", fifo_count, 3'd4);
        chk("pp_drop", drop_cnt, 8'd2);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_count", fifo_count, 3'd0);
        chk("drain_valid", log_valid, 1'b0);
        chk("drain_q_empty", exp_q.size(), 0);

        // Three trojan cycles raise the alarm; three entries queue meanwhile
        do_reset();
        step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        chk("fsm_s1", state_o, 2'd1);
        step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        chk("fsm_s2", state_o, 2'd1);
        chk("fsm_a2", alarm, 1'b0);
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
        chk("fsm_s3", state_o, 2'd2);
        chk("fsm_a3", alarm, 1'b1);
        chk("alarm_q3", fifo_count, 3'd3);
        step(1'b0, 1'b1, 8'h04, 1'b0, 1'b1);
        chk("clr_hi_state", state_o, 2'd2);
        chk("clr_hi_alarm", alarm, 1'b1);

        // Reset while in ALARM with entries queued
        do_reset();
        chk("rA_alarm", alarm, 1'b0);
        chk("rA_state", state_o, 2'd0);
        chk("rA_count", fifo_count, 3'd0);
        chk("rA_drop", drop_cnt, 8'd0);
        chk("rA_valid", log_valid, 1'b0);

        // Clear with trojan low releases the alarm
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("alarm2_state", state_o, 2'd2);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_lo_state", state_o, 2'd0);
        chk("clr_lo_alarm", alarm, 1'b0);

        // Two high then eight quiet cycles (clr_alarm asserted, must be ignored)
        do_reset();
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("q_watch", state_o, 2'd1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            chk($sformatf("q_state_%0d", k), state_o, (k < 8) ? 2'd1 : 2'd0);
            chk($sformatf("q_alarm_%0d", k), alarm, 1'b0);
        end

        // High 2, low 1, high 2 never reaches the threshold
        do_reset();
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("brk_alarm_mid", alarm, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("brk_state", state_o, 2'd1);
        chk("brk_alarm", alarm, 1'b0);

        do_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmr_fault_logger.md
TMR_FAULT_LOGGER -- requirements
Module: tmr_fault_logger

Interface
REQ-001 Parameter WIDTH, default 8: width of the voted data word captured with each event.
REQ-002 Parameter DEPTH, default 4: event FIFO depth; power of two, at least 2.
REQ-003 Parameter TS_W, default 16: timestamp counter width.
REQ-004 Parameter THRESH, default 3: consecutive sus_trojan cycles needed to raise alarm; at least 2.
REQ-005 Parameter QUIET, default 8: consecutive sus_trojan-low cycles in WATCH before returning to IDLE; at least 1.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 data_in  input  WIDTH  voted data word from the upstream TMR stage, sampled every cycle.
REQ-009 fault_flag  input  1  upstream replica-disagreement indication.
REQ-010 sus_trojan  input  1  upstream suspected-trojan indication.
REQ-011 log_ready  input  1  consumer ready for a log entry.
REQ-012 clr_alarm  input  1  operator alarm clear, level, sampled each cycle.
REQ-013 log_valid  output  1  log_data holds a valid entry (FIFO not empty).
REQ-014 log_data  output  2+TS_W+WIDTH  entry: {type[1:0], timestamp[TS_W-1:0], data[WIDTH-1:0]}.
REQ-015 alarm  output  1  high exactly while the FSM is in ALARM.
REQ-016 state_o  output  2  FSM state: IDLE=0, WATCH=1, ALARM=2; 3 is unused.
REQ-017 drop_cnt  output  8  count of dropped events, saturating at 255.
REQ-018 fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 The timestamp counter SHALL increment by 1 every cycle from 0 after reset and wrap modulo 2^TS_W.
REQ-020 Event type SHALL be computed combinationally each cycle as {sus_trojan, fault_flag}: 01 = fault only, 10 = suspected trojan only, 11 = both, 00 = none.
REQ-021 An event SHALL be generated in a cycle where the type is non-zero and differs from the type registered in the previous cycle; a type held constant generates one event only.
REQ-022 The entry SHALL capture that cycle's type, timestamp value and data_in.
REQ-023 A pop SHALL occur when log_valid and log_ready are both high; log_data SHALL show the FIFO head, first-in first-out.
REQ-024 An entry pushed into an empty FIFO SHALL appear on log_data with log_valid high in the next cycle.
REQ-025 Push when not full: entry stored and fifo_count increments, unless a pop occurs in the same cycle, in which case fifo_count is unchanged.
REQ-026 Push when full with a simultaneous pop: the push SHALL be accepted and fifo_count SHALL stay at DEPTH.
REQ-027 Push when full without a pop: the entry SHALL be discarded and drop_cnt incremented, saturating at 255.
REQ-028 Pop when empty SHALL be impossible, since log_valid is low; log_ready is ignored when the FIFO is empty.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 The FSM SHALL use a streak counter for consecutive sus_trojan-high cycles and a quiet counter for consecutive sus_trojan-low cycles.
REQ-031 IDLE: if sus_trojan is high, go to WATCH with streak=1; otherwise stay in IDLE.
REQ-032 WATCH, sus_trojan high: streak+1 is computed and the quiet counter clears; if streak+1 = THRESH, go to ALARM, otherwise stay in WATCH with streak = streak+1.
REQ-033 WATCH, sus_trojan low: streak clears and the quiet counter increments; when it reaches QUIET, go to IDLE and clear it.
REQ-034 ALARM is sticky: it SHALL return to IDLE, clearing both counters, only in a cycle with clr_alarm high and sus_trojan low; otherwise it stays in ALARM.
REQ-035 clr_alarm SHALL have no effect in IDLE or WATCH.
REQ-036 fault_flag SHALL NOT affect the FSM; it is logged only.
REQ-037 alarm and state_o SHALL be registered outputs, with no combinational path from inputs.
REQ-038 Logging and the FSM SHALL operate independently; FIFO full state SHALL NOT stall the FSM.

Reset
REQ-039 On rst high at a clock edge, the block SHALL set:
- timestamp = 0 and previous type = 00;
- FIFO pointers = 0, fifo_count = 0, log_valid = 0;
- drop_cnt = 0;
- state = IDLE, alarm = 0, streak = 0, quiet = 0.
REQ-040 Reset mid-operation SHALL discard all FIFO contents; log_data is don't-care while log_valid = 0.
REQ-041 Inputs sampled in the reset cycle SHALL generate no event.

Verification
REQ-042 Reset, then fault_flag high for cycles 5–9 with data_in=0xA5 and log_ready=1 -> exactly one entry {01, ts=5, 0xA5}; log_valid high for exactly one cycle, at cycle 6.
REQ-043 log_ready=0, then 6 alternating events (fault only, then both, and so on) -> fifo_count=4, drop_cnt=2, first 4 entries read back in order.
REQ-044 FIFO full, then a push and a pop in the same cycle -> fifo_count stays 4, drop_cnt unchanged, new entry is last in the FIFO.
REQ-045 sus_trojan high for 3 cycles from IDLE -> state_o goes 1, 1, 2; alarm=1 on the cycle after the third high; clr_alarm with sus_trojan high -> alarm stays 1; clr_alarm with sus_trojan low -> IDLE next cycle.
REQ-046 sus_trojan high 2 cycles, then low 8 cycles -> state goes WATCH then IDLE after the 8th low cycle, alarm never set; a pattern high 2, low 1, high 2 -> no alarm.
REQ-047 Assert rst while in ALARM with 3 entries queued -> next cycle: alarm=0, state_o=0, fifo_count=0, drop_cnt=0, log_valid=0.
